icache: RTL

Direct-mapped, two-word-block instruction cache between the datapath fetch stage and `memory_control`. It answers fetches from local frames in the same cycle on a hit. On a miss it fills a whole block by issuing two sequential word reads on the instruction side of `memory_control` (`iREN`/`iaddr`, stalled by `iwait`). It is read-only and holds no dirty state.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/icache_if.sv | 25 ++
 rtl/icache_frames.sv | 40 ++++
 rtl/icache.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction cache: word type, cache address split,
// frame layout and fill FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Cache geometry; the icache SETS parameter must match ICACHE_SETS.
    localparam int ICACHE_SETS = 8;
    localparam int IIDX_W      = $clog2(ICACHE_SETS);
    localparam int ITAG_W      = 32 - 3 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic              blkoff;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t [1:0]       data;
    } icache_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache. The cache takes the
// slave view; the datapath/memory_control side (or a bench) takes the master view.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frames.sv
// Frame storage for the instruction cache: valid/tag/two-word data per set,
// one combinational read port and one synchronous write port.
module icache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [IIDX_W-1:0] rd_idx,
    output icache_frame_t     rd_frame,
    input  logic              wr_en,
    input  logic [IIDX_W-1:0] wr_idx,
    input  icache_frame_t     wr_frame
);

    logic [SETS-1:0]   valid;
    logic [ITAG_W-1:0] tags  [SETS];
    word_t [1:0]       words [SETS];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_frame.valid;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; a cleared valid bit masks them.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_frame.tag;
            words[wr_idx] <= wr_frame.data;
        end
    end

    assign rd_frame = '{valid: valid[rd_idx], tag: tags[rd_idx], data: words[rd_idx]};

endmodule

// File: rtl/icache.sv
// Direct-mapped, two-word-block, read-only instruction cache. Hits answer in the same
// cycle; a miss fills the whole block with two sequential reads from memory_control.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int CPUID = 0
) (
    input logic      CLK,
    input logic      nRST,
    icache_if.slave  bus
);

    icache_state_t     state, next_state;
    icachef_t          addr;
    logic [ITAG_W-1:0] fill_tag;
    logic [IIDX_W-1:0] fill_idx;
    word_t             fill_word0;
    icache_frame_t     rd_frame, wr_frame;
    logic              wr_en;
    logic              hit;
    logic              fetch_hit;
    word_t             fetch_word;
    logic              mem_ren;
    word_t             mem_addr;
    logic              unused_bits;

    assign addr = icachef_t'(bus.imemaddr);
    // CPUID only picks the memory_control lane at the top-level hookup.
    assign unused_bits = ^{addr.bytoff, CPUID[0]};

    icache_frames #(.SETS(SETS)) u_frames (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (addr.idx),
        .rd_frame (rd_frame),
        .wr_en    (wr_en),
        .wr_idx   (fill_idx),
        .wr_frame (wr_frame)
    );

    assign hit = rd_frame.valid && (rd_frame.tag == addr.tag);

    always_comb begin
        wr_frame.valid   = 1'b1;
        wr_frame.tag     = fill_tag;
        wr_frame.data[0] = fill_word0;
        wr_frame.data[1] = bus.iload;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        fetch_hit  = 1'b0;
        fetch_word = '0;
        mem_ren    = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                fetch_hit = bus.imemREN && hit && nRST;
                if (fetch_hit) begin
                    fetch_word = rd_frame.data[addr.blkoff];
                end
                if (bus.imemREN && !hit) begin
                    next_state = FETCH0;
                end
            end
            FETCH0: begin
                mem_ren  = 1'b1;
                mem_addr = {fill_tag, fill_idx, 3'b000};
                if (!bus.iwait) begin
                    next_state = FETCH1;
                end
            end
            FETCH1: begin
                mem_ren  = 1'b1;
                mem_addr = {fill_tag, fill_idx, 3'b100};
                if (!bus.iwait) begin
                    next_state = IDLE;
                    wr_en      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            fill_tag   <= '0;
            fill_idx   <= '0;
            fill_word0 <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.imemREN && !hit) begin
                fill_tag <= addr.tag;
                fill_idx <= addr.idx;
            end
            if (state == FETCH0 && !bus.iwait) begin
                fill_word0 <= bus.iload;
            end
        end
    end

    assign bus.ihit     = fetch_hit;
    assign bus.imemload = fetch_word;
    assign bus.iREN     = mem_ren;
    assign bus.iaddr    = mem_addr;

endmodule
